// File: rtl/icache_pkg.sv
// Shared constants and state type for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_INDEX_WIDTH = 8;
  localparam int INST_ADDR_WIDTH    = 32;
  localparam int INST_WIDTH         = 32;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays of the instruction cache: asynchronous read, synchronous write.
module icache_store
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = INST_ADDR_WIDTH - ICACHE_INDEX_WIDTH - 2,
  parameter int DATA_WIDTH  = INST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rindex,
  output logic                   rvalid,
  output logic [TAG_WIDTH-1:0]   rtag,
  output logic [DATA_WIDTH-1:0]  rdata,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] windex,
  input  logic [TAG_WIDTH-1:0]   wtag,
  input  logic [DATA_WIDTH-1:0]  wdata
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic [ENTRIES-1:0]    valid;
  logic [TAG_WIDTH-1:0]  tag_mem  [ENTRIES];
  logic [DATA_WIDTH-1:0] data_mem [ENTRIES];

  // Only the valid bits are reset; stale tag/data are harmless once invalidated.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[windex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_mem[windex]  <= wtag;
      data_mem[windex] <= wdata;
    end
  end

  assign rvalid = valid[rindex];
  assign rtag   = tag_mem[rindex];
  assign rdata  = data_mem[rindex];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hits, single-word miss fetch with
// same-cycle bypass of the returned word, and mispredict flush of an outstanding miss.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = INST_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ex_jmp_wrong_i,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_inst_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic                  inst_require,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [INST_WIDTH-1:0] inst_data,
  input  logic                  inst_enable,
  input  logic                  inst_busy
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  icache_state_e state, state_next;
  logic                  require_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  logic                   rvalid;
  logic [TAG_WIDTH-1:0]   rtag;
  logic [INST_WIDTH-1:0]  rdata;
  logic                   we;
  logic [INDEX_WIDTH-1:0] pc_index;
  logic [TAG_WIDTH-1:0]   pc_tag;
  logic                   hit;
  logic                   flush;

  // The controller's busy flag does not gate requests, and fetches are word-aligned.
  logic unused_bits;
  assign unused_bits = &{1'b0, inst_busy, if_pc[1:0]};

  assign pc_index = if_pc[INDEX_WIDTH+1:2];
  assign pc_tag   = if_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit      = if_req && rvalid && (rtag == pc_tag);
  assign flush    = rdy && ex_jmp_wrong_i;

  icache_store #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .DATA_WIDTH (INST_WIDTH)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .rindex(pc_index),
    .rvalid(rvalid),
    .rtag  (rtag),
    .rdata (rdata),
    .we    (we),
    .windex(inst_addr[INDEX_WIDTH+1:2]),
    .wtag  (inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2]),
    .wdata (inst_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      inst_require <= 1'b0;
      inst_addr    <= '0;
    end else if (rdy) begin
      state        <= state_next;
      inst_require <= require_next;
      inst_addr    <= addr_next;
    end
  end

  // Flush outranks a fill arriving in the same cycle, which in turn outranks a new miss.
  always_comb begin
    state_next    = state;
    require_next  = inst_require;
    addr_next     = inst_addr;
    we            = 1'b0;
    if_inst_valid = 1'b0;
    if_inst       = '0;
    case (state)
      IDLE: begin
        if (hit && !flush) begin
          if_inst_valid = 1'b1;
          if_inst       = rdata;
        end else if (if_req && !hit && !flush) begin
          state_next   = MISS;
          require_next = 1'b1;
          addr_next    = if_pc;
        end
      end
      MISS: begin
        if (flush) begin
          state_next   = IDLE;
          require_next = 1'b0;
        end else if (rdy && inst_enable) begin
          if_inst_valid = 1'b1;
          if_inst       = inst_data;
          we            = 1'b1;
          state_next    = IDLE;
          require_next  = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        require_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by randomized traffic,
// all compared each cycle against a behavioural cache model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, ex_jmp_wrong_i, if_req;
  logic [31:0] if_pc;
  logic        if_inst_valid;
  logic [31:0] if_inst;
  logic        inst_require;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_enable, inst_busy;

  always #5 clk = ~clk;

  icache dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .ex_jmp_wrong_i(ex_jmp_wrong_i),
    .if_req        (if_req),
    .if_pc         (if_pc),
    .if_inst_valid (if_inst_valid),
    .if_inst       (if_inst),
    .inst_require  (inst_require),
    .inst_addr     (inst_addr),
    .inst_data     (inst_data),
    .inst_enable   (inst_enable),
    .inst_busy     (inst_busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: a table of lines plus "is a fetch outstanding, and for which pc".
  bit          m_init = 1'b0;
  bit          m_pending = 1'b0;
  logic [31:0] m_addr = '0;
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];

  logic        seen_valid;
  logic [31:0] seen_inst;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle, compare outputs with the model, then advance the model past the edge.
  task automatic applyStimulus(input bit r, input bit rd, input bit ex, input bit req,
                               input logic [31:0] pc, input bit en, input logic [31:0] data);
    bit          flush, hit;
    int          idx, fidx;
    logic        exp_valid;
    logic [31:0] exp_inst;
    rst = r; rdy = rd; ex_jmp_wrong_i = ex; if_req = req; if_pc = pc;
    inst_enable = en; inst_data = data; inst_busy = m_pending;
    #2;
    seen_valid = if_inst_valid;
    seen_inst  = if_inst;
    idx   = int'(pc[9:2]);
    flush = rd && ex;
    hit   = req && m_valid[idx] && (m_tag[idx] == pc[31:10]);
    if (m_pending) exp_valid = rd && en && !flush;
    else           exp_valid = hit && !flush;
    exp_inst = !exp_valid ? 32'h0 : (m_pending ? data : m_data[idx]);
    if (m_init) begin
      checkOutput("if_inst_valid", {31'b0, if_inst_valid}, {31'b0, exp_valid});
      checkOutput("if_inst", if_inst, exp_inst);
      checkOutput("inst_require", {31'b0, inst_require}, {31'b0, m_pending});
      checkOutput("inst_addr", inst_addr, m_addr);
    end
    @(posedge clk);
    if (r) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_pending = 1'b0;
      m_addr    = '0;
      m_init    = 1'b1;
    end else if (rd) begin
      if (flush) begin
        m_pending = 1'b0;
      end else if (m_pending && en) begin
        fidx = int'(m_addr[9:2]);
        m_valid[fidx] = 1'b1;
        m_tag[fidx]   = m_addr[31:10];
        m_data[fidx]  = data;
        m_pending     = 1'b0;
      end else if (!m_pending && req && !hit) begin
        m_pending = 1'b1;
        m_addr    = pc;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    bit req, ex, rd, en, r;
    rst = 1'b0; rdy = 1'b0; ex_jmp_wrong_i = 1'b0; if_req = 1'b0; if_pc = '0;
    inst_data = '0; inst_enable = 1'b0; inst_busy = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
    checkOutput("reset_require", {31'b0, inst_require}, 32'h0);
    checkOutput("reset_addr", inst_addr, 32'h0);

    // Cold miss with a four-cycle memory latency.
    applyStimulus(0, 1, 0, 1, 32'h10, 0, 32'h0);
    checkOutput("t1_require", {31'b0, inst_require}, 32'h1);
    checkOutput("t1_addr", inst_addr, 32'h10);
    repeat (3) applyStimulus(0, 1, 0, 1, 32'h10, 0, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'h10, 1, 32'h93);
    checkOutput("t1_bypass_valid", {31'b0, seen_valid}, 32'h1);
    checkOutput("t1_bypass_inst", seen_inst, 32'h93);
    checkOutput("t1_require_drop", {31'b0, inst_require}, 32'h0);

    // Hit after fill.
    applyStimulus(0, 1, 0, 1, 32'h10, 0, 32'h0);
    checkOutput("t2_hit_valid", {31'b0, seen_valid}, 32'h1);
    checkOutput("t2_hit_inst", seen_inst, 32'h93);
    checkOutput("t2_no_require", {31'b0, inst_require}, 32'h0);

    // Conflict miss on a shared index.
    applyStimulus(0, 1, 0, 1, 32'h0, 0, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'h0, 1, 32'h13);
    applyStimulus(0, 1, 0, 1, 32'h400, 0, 32'h0);
    checkOutput("t3_conflict_miss", {31'b0, seen_valid}, 32'h0);
    checkOutput("t3_conflict_addr", inst_addr, 32'h400);
    applyStimulus(0, 1, 0, 1, 32'h400, 1, 32'h33);
    applyStimulus(0, 1, 0, 1, 32'h0, 0, 32'h0);
    checkOutput("t3_evicted_miss", {31'b0, seen_valid}, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'h0, 1, 32'h13);

    // Flush with a fill in the same cycle discards the word.
    applyStimulus(0, 1, 0, 1, 32'h20, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 32'h20, 1, 32'hDEADBEEF);
    checkOutput("t4_flush_valid", {31'b0, seen_valid}, 32'h0);
    checkOutput("t4_flush_require", {31'b0, inst_require}, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'h20, 0, 32'h0);
    checkOutput("t4_refetch_miss", {31'b0, seen_valid}, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'h20, 1, 32'h77);

    // rdy stall while the controller pulses enable.
    applyStimulus(0, 1, 0, 1, 32'h30, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h30, 1, 32'hBAD);
      checkOutput("t5_stall_require", {31'b0, inst_require}, 32'h1);
    end
    applyStimulus(0, 1, 0, 1, 32'h30, 1, 32'h55);
    checkOutput("t5_fill_inst", seen_inst, 32'h55);
    applyStimulus(0, 1, 0, 1, 32'h30, 0, 32'h0);
    checkOutput("t5_hit_inst", seen_inst, 32'h55);

    // Reset while a miss is outstanding.
    applyStimulus(0, 1, 0, 1, 32'h40, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 32'h40, 0, 32'h0);
    checkOutput("t6_reset_require", {31'b0, inst_require}, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'h10, 0, 32'h0);
    checkOutput("t6_cleared_miss", {31'b0, seen_valid}, 32'h0);
    checkOutput("t6_new_require", {31'b0, inst_require}, 32'h1);
    applyStimulus(0, 1, 0, 1, 32'h10, 1, 32'h93);

    // Random traffic over a few indices and tags to provoke hits, conflicts and flushes.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      rd = ($urandom_range(0, 7) != 0);
      ex = ($urandom_range(0, 15) == 0);
      if (m_pending) begin
        req = 1'b1;
        pc  = m_addr;
        en  = ($urandom_range(0, 2) == 0);
      end else begin
        req = ($urandom_range(0, 3) != 0);
        pc  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2);
        if ($urandom_range(0, 15) == 0) pc = $urandom & 32'hFFFF_FFFC;
        en  = 1'b0;
      end
      applyStimulus(r, rd, ex, req, pc, en, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
